// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath width, register count and the
// writeback entry carried by the long-latency result buffer.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int AW         = $clog2(NREG);
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t for long-latency results.
// Pointers carry one extra wrap bit to tell full from empty.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  wb_entry_t i_din,
    input  logic      i_pop,
    output wb_entry_t o_dout,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t       r_mem [DEPTH];
    logic [PW:0]     r_wptr;
    logic [PW:0]     r_rptr;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) &&
                     (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rptr[PW-1:0]];

    // Pointer update; wraps modulo DEPTH via the index slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Entry storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= i_din;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: ALU vs buffered long-latency
// results, plus pending-destination scoreboard. Option: WB_BYPASS_EN.
module regfile_writeback
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_addr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [AW-1:0]   ll_addr,
    input  logic [XLEN-1:0] ll_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic [AW-1:0]   q_addr1,
    input  logic [AW-1:0]   q_addr2,
    output logic            q_busy1,
    output logic            q_busy2,
`ifdef WB_BYPASS_EN
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
`endif
    output logic            wb_we,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data
);

    wb_entry_t       w_head;
    wb_entry_t       w_din;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_sel_fifo;
    logic            w_sel_alu;
    logic [AW-1:0]   w_win_addr;
    logic [XLEN-1:0] w_win_data;
    logic [NREG-1:0] w_busy_nxt;

    logic            r_wb_we;
    logic            r_wb_ll;
    logic [AW-1:0]   r_wb_addr;
    logic [XLEN-1:0] r_wb_data;
    logic [NREG-1:0] r_busy;

    assign w_din.addr = ll_addr;
    assign w_din.data = ll_data;
    assign w_push     = ll_valid && !w_full;

    wb_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_sel_fifo),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A full FIFO blocks the ALU so it cannot starve queued results
    assign ll_ready   = !w_full;
    assign alu_ready  = !w_full;
    assign w_sel_fifo = !w_empty && (w_full || !alu_valid);
    assign w_sel_alu  = !w_full && alu_valid;
    assign w_win_addr = w_sel_fifo ? w_head.addr : alu_addr;
    assign w_win_data = w_sel_fifo ? w_head.data : alu_data;

    // Write-port registers; an x0 winner is consumed but not written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_we   <= 1'b0;
            r_wb_ll   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_we <= (w_sel_fifo || w_sel_alu) && (w_win_addr != '0);
            r_wb_ll <= w_sel_fifo;
            if (w_sel_fifo || w_sel_alu) begin
                r_wb_addr <= w_win_addr;
                r_wb_data <= w_win_data;
            end
        end
    end

    // Scoreboard next state: clear first so a same-edge issue wins
    always_comb begin
        w_busy_nxt = r_busy;
`ifdef WB_BYPASS_EN
        if (w_sel_fifo)
            w_busy_nxt[w_head.addr] = 1'b0;
`else
        if (r_wb_we && r_wb_ll)
            w_busy_nxt[r_wb_addr] = 1'b0;
`endif
        if (iss_valid)
            w_busy_nxt[iss_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    assign q_busy1 = (q_addr1 != '0) && r_busy[q_addr1];
    assign q_busy2 = (q_addr2 != '0) && r_busy[q_addr2];

`ifdef WB_BYPASS_EN
    assign fwd_hit1  = r_wb_we && (r_wb_addr == q_addr1) && (q_addr1 != '0);
    assign fwd_hit2  = r_wb_we && (r_wb_addr == q_addr2) && (q_addr2 != '0);
    assign fwd_data1 = r_wb_data;
    assign fwd_data2 = r_wb_data;
`endif

    assign wb_we   = r_wb_we;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: vector table for
// arbitration, hand sequences for scoreboard and async reset.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ll_valid, iss_valid;
    logic        alu_ready, ll_ready;
    logic [4:0]  alu_addr, ll_addr, iss_addr, q_addr1, q_addr2;
    logic [31:0] alu_data, ll_data;
    logic        q_busy1, q_busy2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef WB_BYPASS_EN
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int checks = 0;
    int failures = 0;

    regfile_writeback dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ll_valid  (ll_valid),
        .ll_ready  (ll_ready),
        .ll_addr   (ll_addr),
        .ll_data   (ll_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .q_addr1   (q_addr1),
        .q_addr2   (q_addr2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
`ifdef WB_BYPASS_EN
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
`endif
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_ardy;
        logic        e_lrdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic ear, input logic elr,
        input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ld = ld;
        v.e_ardy = ear; v.e_lrdy = elr;
        v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ll_valid  = 1'b0; ll_addr  = '0; ll_data  = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // arbitration: ALU only, collision, FIFO full, x0 write
        tbl[0]  = mk(1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,
                     1'b1, 1'b1, 1'b0, 5'd0,  32'h0);
        tbl[1]  = mk(1'b1, 5'd3,  32'hA,    1'b1, 5'd7,  32'hB,
                     1'b1, 1'b1, 1'b1, 5'd5,  32'h1234);
        tbl[2]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                     1'b1, 1'b1, 1'b1, 5'd3,  32'hA);
        tbl[3]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                     1'b1, 1'b1, 1'b1, 5'd7,  32'hB);
        tbl[4]  = mk(1'b1, 5'd1,  32'h11,   1'b1, 5'd10, 32'h100,
                     1'b1, 1'b1, 1'b0, 5'd0,  32'h0);
        tbl[5]  = mk(1'b1, 5'd2,  32'h22,   1'b1, 5'd11, 32'h101,
                     1'b1, 1'b1, 1'b1, 5'd1,  32'h11);
        tbl[6]  = mk(1'b1, 5'd3,  32'h33,   1'b0, 5'd0,  32'h0,
                     1'b0, 1'b0, 1'b1, 5'd2,  32'h22);
        tbl[7]  = mk(1'b1, 5'd3,  32'h33,   1'b0, 5'd0,  32'h0,
                     1'b1, 1'b1, 1'b1, 5'd10, 32'h100);
        tbl[8]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                     1'b1, 1'b1, 1'b1, 5'd3,  32'h33);
        tbl[9]  = mk(1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0,  32'h0,
                     1'b1, 1'b1, 1'b1, 5'd11, 32'h101);
        tbl[10] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                     1'b1, 1'b1, 1'b0, 5'd0,  32'h0);
        tbl[11] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                     1'b1, 1'b1, 1'b0, 5'd0,  32'h0);

        idle();
        q_addr1 = 5'd9;
        q_addr2 = 5'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
        chk("reset_wb_we", 32'(wb_we), 32'd0);
        chk("reset_wb_addr", 32'(wb_addr), 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_ll_ready", 32'(ll_ready), 32'd1);
        chk("reset_q_busy1", 32'(q_busy1), 32'd0);

        for (int i = 0; i < 12; i++) begin
            alu_valid = tbl[i].av; alu_addr = tbl[i].aa;
            alu_data  = tbl[i].ad;
            ll_valid  = tbl[i].lv; ll_addr  = tbl[i].la;
            ll_data   = tbl[i].ld;
            @(negedge clk);
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready),
                32'(tbl[i].e_ardy));
            chk($sformatf("v%0d_ll_ready", i), 32'(ll_ready),
                32'(tbl[i].e_lrdy));
            chk($sformatf("v%0d_wb_we", i), 32'(wb_we),
                32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d_wb_addr", i), 32'(wb_addr),
                    32'(tbl[i].e_wa));
                chk($sformatf("v%0d_wb_data", i), wb_data, tbl[i].e_wd);
            end
            next_cycle();
        end
        idle();

        // scoreboard: issue x9, complete it through the FIFO
        q_addr1 = 5'd9;
        q_addr2 = 5'd9;
        iss_valid = 1'b1; iss_addr = 5'd9;
        @(negedge clk);
        chk("sb_before_issue", 32'(q_busy1), 32'd0);
        next_cycle();
        idle();
        ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'hBEEF;
        @(negedge clk);
        chk("sb_busy1_set", 32'(q_busy1), 32'd1);
        chk("sb_busy2_set", 32'(q_busy2), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("sb_busy_queued", 32'(q_busy1), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("sb_wb_we", 32'(wb_we), 32'd1);
        chk("sb_wb_addr", 32'(wb_addr), 32'd9);
        chk("sb_wb_data", wb_data, 32'hBEEF);
`ifdef WB_BYPASS_EN
        chk("sb_busy_at_wb", 32'(q_busy1), 32'd0);
        chk("sb_fwd_hit1", 32'(fwd_hit1), 32'd1);
        chk("sb_fwd_data1", fwd_data1, 32'hBEEF);
`else
        chk("sb_busy_at_wb", 32'(q_busy1), 32'd1);
`endif
        next_cycle();
        @(negedge clk);
        chk("sb_busy_cleared", 32'(q_busy1), 32'd0);
        chk("sb_wb_we_idle", 32'(wb_we), 32'd0);

        // issue to x0 never marks
        iss_valid = 1'b1; iss_addr = 5'd0;
        q_addr1 = 5'd0;
        next_cycle();
        idle();
        @(negedge clk);
        chk("sb_x0_busy", 32'(q_busy1), 32'd0);
        q_addr1 = 5'd9;

        // same-edge issue and clear of x9: issue must win
        iss_valid = 1'b1; iss_addr = 5'd9;
        next_cycle();
        idle();
        ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'h55;
        next_cycle();
        idle();
`ifdef WB_BYPASS_EN
        iss_valid = 1'b1; iss_addr = 5'd9;
`endif
        next_cycle();
        idle();
`ifndef WB_BYPASS_EN
        iss_valid = 1'b1; iss_addr = 5'd9;
`endif
        @(negedge clk);
        chk("sb_race_wb_we", 32'(wb_we), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("sb_race_busy", 32'(q_busy1), 32'd1);

        // async reset while FIFO is full and x4 is pending
        q_addr2 = 5'd4;
        iss_valid = 1'b1; iss_addr = 5'd4;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h77;
        ll_valid = 1'b1; ll_addr = 5'd12; ll_data = 32'hC;
        next_cycle();
        iss_valid = 1'b0;
        ll_addr = 5'd13; ll_data = 32'hD;
        next_cycle();
        ll_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_ll_ready", 32'(ll_ready), 32'd0);
        chk("rst_pre_busy2", 32'(q_busy2), 32'd1);
        chk("rst_pre_wb_we", 32'(wb_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_wb_we", 32'(wb_we), 32'd0);
        chk("rst_async_ll_ready", 32'(ll_ready), 32'd1);
        chk("rst_async_busy1", 32'(q_busy1), 32'd0);
        chk("rst_async_busy2", 32'(q_busy2), 32'd0);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_post_wb_we", 32'(wb_we), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rst_post_wb_we2", 32'(wb_we), 32'd0);
        chk("rst_post_ll_ready", 32'(ll_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
